// File: rtl/serial_parity_deserializer_pkg.sv
// Shared types and helpers for the serial parity deserializer.
// Provides the frame state enum, parity polarity codes and counter sizing.
package serial_parity_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        PARITY  = 1'b1
    } state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Wide enough to hold WIDTH itself, which marks "waiting for parity bit".
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_parity_deserializer_if.sv
// Serial-in / parallel-out handshake bundle for the deserializer.
// slave: deserializer side; master: stream source plus word sink.
// Macro SERIAL_PARITY_CHECK_EN adds the parity_err signal.
interface serial_parity_deserializer_if #(
    parameter int WIDTH = 8
) ();

    logic             serial_valid;
    logic             serial_data;
    logic             serial_ready;
    logic             parallel_valid;
    logic             parallel_ready;
    logic [WIDTH-1:0] parallel_data;
    logic             parallel_parity;
`ifdef SERIAL_PARITY_CHECK_EN
    logic             parity_err;

    modport slave (
        input  serial_valid, serial_data, parallel_ready,
        output serial_ready, parallel_valid, parallel_data,
        output parallel_parity, parity_err
    );

    modport master (
        output serial_valid, serial_data, parallel_ready,
        input  serial_ready, parallel_valid, parallel_data,
        input  parallel_parity, parity_err
    );
`else
    modport slave (
        input  serial_valid, serial_data, parallel_ready,
        output serial_ready, parallel_valid, parallel_data,
        output parallel_parity
    );

    modport master (
        output serial_valid, serial_data, parallel_ready,
        input  serial_ready, parallel_valid, parallel_data,
        input  parallel_parity
    );
`endif

endinterface

// File: rtl/serial_parity_deserializer_acc.sv
// parity_accumulator: 1-bit running XOR of accepted serial bits.
// Ports: clk, rst (sync, active-high), clr (restart), en, d, acc.
module parity_accumulator (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic d,
    output logic acc
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc <= 1'b0;
        end else if (en) begin
            acc <= acc ^ d;
        end
    end

endmodule

// File: rtl/serial_parity_deserializer.sv
// LSB-first serial to WIDTH-bit parallel deserializer with word parity.
// Ports: clk, rst (sync, active-high), bus (serial_parity_deserializer_if.slave).
// Macro SERIAL_PARITY_CHECK_EN: frames carry a trailing parity bit which is
// checked, reported on parity_err and forwarded as parallel_parity.
module serial_parity_deserializer
    import serial_parity_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic clk,
    input  logic rst,
    serial_parity_deserializer_if.slave bus
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic          POL  = PARITY_ODD ? PAR_ODD : PAR_EVEN;

    logic             accept;
    logic             done;
    logic             acc;
    logic             acc_en;
    logic             word_par;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_nxt;
    logic [WIDTH-1:0] word;

    // Only depends on the output register state, never on serial_valid.
    assign bus.serial_ready = !bus.parallel_valid || bus.parallel_ready;
    assign accept           = bus.serial_valid && bus.serial_ready;

`ifdef SERIAL_PARITY_CHECK_EN
    state_t state;
    state_t state_nxt;
    logic   err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    // Counter parks at WIDTH while the parity bit is awaited.
    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        cnt_nxt   = cnt;
        sr_nxt    = sr;
        acc_en    = 1'b0;
        word      = sr;
        word_par  = bus.serial_data;
        unique case (state)
            COLLECT: begin
                if (accept) begin
                    sr_nxt = {bus.serial_data, sr[WIDTH-1:1]};
                    acc_en = 1'b1;
                    if (cnt == LAST) begin
                        cnt_nxt   = CW'(WIDTH);
                        state_nxt = PARITY;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            PARITY: begin
                if (accept) begin
                    done      = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = COLLECT;
                end
            end
        endcase
    end

    assign err = bus.serial_data != (acc ^ POL);
`else
    // The final data bit is folded in combinationally so the word and its
    // parity load the output register on the same edge that accepts it.
    always_comb begin
        done     = 1'b0;
        cnt_nxt  = cnt;
        sr_nxt   = sr;
        acc_en   = accept;
        word_par = acc ^ bus.serial_data ^ POL;
        if (accept) begin
            sr_nxt = {bus.serial_data, sr[WIDTH-1:1]};
            if (cnt == LAST) begin
                done    = 1'b1;
                cnt_nxt = '0;
            end else begin
                cnt_nxt = cnt + CW'(1);
            end
        end
        word = sr_nxt;
    end
`endif

    parity_accumulator u_acc (
        .clk (clk),
        .rst (rst),
        .clr (done),
        .en  (acc_en),
        .d   (bus.serial_data),
        .acc (acc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            sr  <= '0;
        end else begin
            cnt <= cnt_nxt;
            sr  <= sr_nxt;
        end
    end

    // A completing word wins over a drain in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.parallel_valid  <= 1'b0;
            bus.parallel_data   <= '0;
            bus.parallel_parity <= 1'b0;
`ifdef SERIAL_PARITY_CHECK_EN
            bus.parity_err      <= 1'b0;
`endif
        end else if (done) begin
            bus.parallel_valid  <= 1'b1;
            bus.parallel_data   <= word;
            bus.parallel_parity <= word_par;
`ifdef SERIAL_PARITY_CHECK_EN
            bus.parity_err      <= err;
`endif
        end else if (bus.parallel_ready) begin
            bus.parallel_valid  <= 1'b0;
        end
    end

endmodule
